// File: rtl/stream_mux_4x1.sv
// -----------------------------------------------------------------------------
// stream_mux_4x1
//
// Merges four valid/ready packet streams into one output stream. Arbitration
// is round-robin at packet granularity: once the first word of a multi-word
// packet is accepted from a channel, that channel is locked until its last
// word passes, so packets are never interleaved on the output.
//
// The output side is a single register stage driven only from flops. A new
// word can be loaded whenever the register is empty or is being drained in
// the same cycle, which gives full 1 word/cycle throughput.
//
// Ports
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - per-channel word valid (bit k = channel k)
//   in_data    - channel k data at [k*WIDTH +: WIDTH]
//   in_last    - per-channel end-of-packet flag, qualified by in_valid[k]
//   in_ready   - per-channel accept, at most one bit high
//   out_valid  - output word valid
//   out_data   - output word
//   out_last   - end-of-packet flag of the output word
//   out_sel    - source channel of the output word
//   out_ready  - downstream accept
//
// FSM states
//   state | meaning
//   ARB   | no packet open; round-robin search starting at ptr
//   HOLD  | packet open on lock_ch; only lock_ch may be accepted
// -----------------------------------------------------------------------------
module stream_mux_4x1 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    input  logic [3:0]           in_last,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [1:0]           out_sel,
    input  logic                 out_ready
);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [1:0]         ptr_q,       ptr_d;
    logic [1:0]         lock_ch_q,   lock_ch_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic [1:0]         out_sel_q,   out_sel_d;

    logic               load_en;
    logic               grant_vld;
    logic [1:0]         grant_ch;
    logic               accept;
    logic [WIDTH-1:0]   grant_data;
    logic               grant_last;

    // The output register can take a new word when it is empty or when its
    // current word leaves this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection. In ARB the search walks ptr, ptr+1, ptr+2, ptr+3; the
    // loop runs from the farthest offset down so the nearest valid channel is
    // the one left standing. In HOLD only the locked channel is considered.
    always_comb begin
        logic [1:0] cand;
        grant_vld = 1'b0;
        grant_ch  = ptr_q;
        cand      = ptr_q;
        if (state_q == HOLD) begin
            grant_ch  = lock_ch_q;
            grant_vld = in_valid[lock_ch_q];
        end else begin
            for (int i = 3; i >= 0; i--) begin
                cand = ptr_q + 2'(i);
                if (in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_ch  = cand;
                end
            end
        end
    end

    assign accept     = load_en && grant_vld;
    assign grant_data = in_data[grant_ch*WIDTH +: WIDTH];
    assign grant_last = in_last[grant_ch];

    // rst_n gates the ready vector so nothing is offered upstream while the
    // block is held in reset, even though the registers already read idle.
    always_comb begin
        in_ready = 4'b0000;
        if (accept && rst_n) begin
            in_ready = 4'b0001 << grant_ch;
        end
    end

    // Next-state: packet tracking and round-robin pointer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_ch_d = lock_ch_q;
        if (accept) begin
            if (grant_last) begin
                // Packet closes: next search starts one past the sender, so a
                // single-word packet never visits HOLD.
                state_d = ARB;
                ptr_d   = grant_ch + 2'd1;
            end else if (state_q == ARB) begin
                state_d   = HOLD;
                lock_ch_d = grant_ch;
            end
        end
    end

    // Output register: load on accept, clear valid on a drain without a
    // refill, otherwise hold every field.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_last_d  = grant_last;
            out_sel_d   = grant_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= 2'd0;
            lock_ch_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_4x1.sv
module tb_stream_mux_4x1;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_last;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready;

    int n_checks;
    int n_pass;

    // Reference model: a packet is "open" on a channel between its first and
    // last word; the output register is one slot.
    bit           m_ov;
    logic [W-1:0] m_data;
    bit           m_last;
    int           m_sel;
    bit           m_open;
    int           m_lock;
    int           m_ptr;

    stream_mux_4x1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ov   = 0;
        m_data = '0;
        m_last = 0;
        m_sel  = 0;
        m_open = 0;
        m_lock = 0;
        m_ptr  = 0;
    endfunction

    function automatic logic [3:0] exp_ready();
        if (!rst_n) return 4'b0000;
        if (m_ov && !out_ready) return 4'b0000;
        if (m_open) return in_valid[m_lock] ? 4'(1 << m_lock) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (in_valid[k]) return 4'(1 << k);
        end
        return 4'b0000;
    endfunction

    function automatic void model_clock();
        logic [3:0] r;
        int k;
        r = exp_ready();
        k = 0;
        for (int i = 0; i < 4; i++) if (r[i]) k = i;
        if (r != 4'b0000) begin
            m_ov   = 1;
            m_data = in_data[k*W +: W];
            m_last = in_last[k];
            m_sel  = k;
            if (in_last[k]) begin
                m_open = 0;
                m_ptr  = (k + 1) % 4;
            end else begin
                m_open = 1;
                m_lock = k;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
    endfunction

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic tick();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = $urandom;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) $display("FAIL rst_in_ready: got %b want 0000", in_ready);
        else n_pass++;
        n_checks++;
        if ({out_valid, out_last, out_sel, out_data} !== '0)
            $display("FAIL rst_outputs: got v=%b l=%b s=%0d d=%h want all 0", out_valid, out_last, out_sel, out_data);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000)
            $display("FAIL rst_held: got v=%b rdy=%b want v=0 rdy=0000", out_valid, in_ready);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            #1;
            n_checks++;
            if (in_ready !== 4'(1 << (i % 4)) || in_ready !== exp_ready())
                $display("FAIL rst_rr_grant[%0d]: got %b want %b", i, in_ready, 4'(1 << (i % 4)));
            else n_pass++;
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1)
            $display("FAIL rst_pre_midreset: got v=%b s=%0d want v=1 s=1", out_valid, out_sel);
        else n_pass++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd0 || in_ready !== 4'b0000)
            $display("FAIL rst_async: got v=%b s=%0d rdy=%b want v=0 s=0 rdy=0000", out_valid, out_sel, in_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        in_valid = 4'b0100;
        in_last  = 4'b0000;
        in_data  = $urandom;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) $display("FAIL midpkt_first: got %b want 0100", in_ready);
        else n_pass++;
        tick();
        in_valid = 4'hF;
        in_last  = 4'hF;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100 || in_ready !== exp_ready())
            $display("FAIL midpkt_locked: got %b want 0100", in_ready);
        else n_pass++;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) $display("FAIL midpkt_restart: got %b want 0001", in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_single_word();
        in_valid = 4'b0000;
        tick();
        tick();
        in_valid = 4'b0100;
        in_last  = 4'b0100;
        in_data  = $urandom;
        in_data[2*W +: W] = 8'hA5;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if ({out_valid, out_data, out_sel, out_last} !== {1'b1, 8'hA5, 2'd2, 1'b1})
            $display("FAIL single_out: got v=%b d=%h s=%0d l=%b want v=1 d=a5 s=2 l=1",
                     out_valid, out_data, out_sel, out_last);
        else n_pass++;
        in_valid = 4'hF;
        in_last  = 4'hF;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) $display("FAIL single_ptr3: got %b want 1000", in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_packet_lock();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h12; words[2] = 8'h13;
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        in_data   = $urandom;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) $display("FAIL lock_setup: got %b want 0001", in_ready);
        else n_pass++;
        tick();
        for (int j = 0; j < 3; j++) begin
            in_valid = 4'b0011;
            in_data  = $urandom;
            in_data[0 +: W] = 8'h0F;
            in_data[W +: W] = words[j];
            in_last  = {2'b00, (j == 2), 1'b1};
            #1;
            n_checks++;
            if (in_ready !== 4'b0010) $display("FAIL lock_ready[%0d]: got %b want 0010", j, in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if ({out_valid, out_data, out_sel, out_last} !== {1'b1, words[j], 2'd1, (j == 2)})
                $display("FAIL lock_out[%0d]: got v=%b d=%h s=%0d l=%b want d=%h s=1",
                         j, out_valid, out_data, out_sel, out_last, words[j]);
            else n_pass++;
        end
        in_valid = 4'b0001;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) $display("FAIL lock_release: got %b want 0001", in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 8'h0F)
            $display("FAIL lock_after: got s=%0d d=%h want s=0 d=0f", out_sel, out_data);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_d;
        logic [1:0]   held_s;
        int           words_out;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = $urandom;
        out_ready = 1'b1;
        #1;
        tick();
        held_d = m_data;
        held_s = 2'(m_sel);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_sel !== held_s)
                $display("FAIL bp_stable[%0d]: got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                         i, out_valid, out_data, out_sel, held_d, held_s);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        words_out = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            #1;
            n_checks++;
            if (in_ready !== exp_ready()) $display("FAIL bp_resume_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            else n_pass++;
            tick();
            if (out_valid === 1'b1) words_out++;
            n_checks++;
            if ({out_data, out_sel, out_last} !== {m_data, 2'(m_sel), m_last})
                $display("FAIL bp_resume_out[%0d]: got d=%h s=%0d want d=%h s=%0d", i, out_data, out_sel, m_data, m_sel);
            else n_pass++;
        end
        n_checks++;
        if (words_out !== 8) $display("FAIL bp_throughput: got %0d words want 8", words_out);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int exp_sel;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        exp_sel   = m_ptr;
        for (int i = 0; i < 12; i++) begin
            in_data = $urandom;
            #1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_sel) || out_data !== m_data)
                $display("FAIL fair[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, out_valid, out_sel, out_data, exp_sel, m_data);
            else n_pass++;
            exp_sel = (exp_sel + 1) % 4;
        end
    endtask

    task automatic test_idle();
        int saved_ptr;
        saved_ptr = m_ptr;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1)
            $display("FAIL idle_first: got rdy=%b v=%b want rdy=0000 v=1", in_ready, out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL idle_drain: got v=%b want 0", out_valid);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000)
            $display("FAIL idle_quiet: got v=%b rdy=%b want v=0 rdy=0000", out_valid, in_ready);
        else n_pass++;
        in_valid = 4'hF;
        in_last  = 4'hF;
        #1;
        n_checks++;
        if (in_ready !== 4'(1 << saved_ptr)) $display("FAIL idle_ptr: got %b want %b", in_ready, 4'(1 << saved_ptr));
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (in_ready !== exp_ready()) begin
                $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
                errs++;
            end else n_pass++;
            tick();
            n_checks++;
            if (out_valid !== m_ov || (m_ov && {out_data, out_sel, out_last} !== {m_data, 2'(m_sel), m_last})) begin
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d l=%b want v=%b d=%h s=%0d l=%b",
                         i, out_valid, out_data, out_sel, out_last, m_ov, m_data, m_sel, m_last);
                errs++;
            end else n_pass++;
            if (errs > 10) break;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_reset_mid_packet();
        test_single_word();
        test_packet_lock();
        test_backpressure();
        test_fairness();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
